// File: rtl/addsub_pkg.sv
// Shared arithmetic types and the add/sub primitive used by addsub and addsub_divider.
package addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

    localparam int DIV_W_DEFAULT = 8;
    // Widest operand the shared add/sub primitive handles; callers truncate the result.
    localparam int ADDSUB_MAX_W  = 33;

    function automatic logic [ADDSUB_MAX_W-1:0] add_sub(
        input logic [ADDSUB_MAX_W-1:0] a,
        input logic [ADDSUB_MAX_W-1:0] b,
        input logic                    sel
    );
        return sel ? a + b : a - b;
    endfunction

endpackage

// File: rtl/addsub_divider_if.sv
// Operand/result handshake bundle for the divider; slave is the divider side.
import addsub_pkg::*;

interface addsub_divider_if #(parameter int WIDTH = DIV_W_DEFAULT);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/addsub_divider_step.sv
// One non-restoring step on the WIDTH+1 bit partial remainder; with fix=1 it is the
// final correction (unshifted, always add) applied by the caller only when P is negative.
import addsub_pkg::*;

module addsub_step #(parameter int WIDTH = DIV_W_DEFAULT) (
    input  logic [WIDTH:0]   p,
    input  logic             a_msb,
    input  logic [WIDTH-1:0] d,
    input  logic             fix,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);
    logic [WIDTH:0] opnd;
    logic           sel;

    always_comb begin
        opnd   = fix ? p : {p[WIDTH-1:0], a_msb};
        // Negative partial remainder adds the divisor back, otherwise subtract.
        sel    = fix ? 1'b1 : p[WIDTH];
        p_next = (WIDTH+1)'(add_sub(ADDSUB_MAX_W'(opnd), ADDSUB_MAX_W'(d), sel));
        q_bit  = ~p_next[WIDTH];
    end
endmodule

// File: rtl/addsub_divider.sv
// Iterative unsigned non-restoring divider: WIDTH+2 cycles accept-to-result (1 for /0);
// one op in flight, in_ready low until the result handshakes, outputs held under backpressure.
import addsub_pkg::*;

module addsub_divider #(parameter int WIDTH = DIV_W_DEFAULT) (
    input logic             clk,
    input logic             rst,
    addsub_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p_q;
    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] d_q;
    logic             q_bit;
    logic             out_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    addsub_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .a_msb  (a_q[WIDTH-1]),
        .d      (d_q),
        .fix    (state == FIX),
        .p_next (p_nxt),
        .q_bit  (q_bit)
    );

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p_q         <= '0;
            a_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    d_q   <= bus.divisor;
                    a_q   <= bus.dividend;
                    p_q   <= '0;
                    dbz_q <= 1'b0;
                    if (bus.divisor == '0) begin
                        quotient_q  <= '1;
                        remainder_q <= bus.dividend;
                        dbz_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt   <= CW'(WIDTH - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    p_q <= p_nxt;
                    a_q <= {a_q[WIDTH-2:0], q_bit};
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    quotient_q  <= a_q;
                    remainder_q <= p_q[WIDTH] ? p_nxt[WIDTH-1:0] : p_q[WIDTH-1:0];
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_divider.sv
// Scoreboard bench: stimulus queues expected results, negedge monitors compare DUT outputs.
`timescale 1ns/1ps
module tb_addsub_divider;
    import addsub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_divider_if #(.WIDTH(8))  i8 ();
    addsub_divider_if #(.WIDTH(16)) i16 ();

    addsub_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
    addsub_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // 8-bit monitor
    int   lat8;
    bit   busy8  = 1'b0;
    bit   first8 = 1'b1;
    exp_t e8;
    always @(negedge clk) begin
        if (rst) begin
            busy8  = 1'b0;
            first8 = 1'b1;
        end else begin
            if (busy8) lat8++;
            if (i8.out_valid) begin
                if (sb8.size() == 0) chk("w8_unexpected_out", 1, 0);
                else begin
                    e8 = sb8[0];
                    chk("w8_quotient", i8.quotient, e8.q);
                    chk("w8_remainder", i8.remainder, e8.r);
                    chk("w8_div_by_zero", i8.div_by_zero, e8.z);
                    chk("w8_in_ready_busy", i8.in_ready, 0);
                    if (first8) begin
                        chk("w8_latency", lat8, e8.lat);
                        if (!e8.z) begin
                            chk("w8_q_times_d_plus_r", longint'(i8.quotient) * longint'(e8.b)
                                + longint'(i8.remainder), e8.a);
                            chk("w8_r_lt_d", longint'(i8.remainder < e8.b[7:0]), 1);
                        end
                        first8 = 1'b0;
                        busy8  = 1'b0;
                    end
                    if (i8.out_ready) begin
                        void'(sb8.pop_front());
                        first8 = 1'b1;
                    end
                end
            end
            if (i8.in_valid && i8.in_ready) begin
                busy8 = 1'b1;
                lat8  = 0;
            end
        end
    end

    // 16-bit monitor
    int   lat16;
    bit   busy16  = 1'b0;
    bit   first16 = 1'b1;
    exp_t e16;
    always @(negedge clk) begin
        if (rst) begin
            busy16  = 1'b0;
            first16 = 1'b1;
        end else begin
            if (busy16) lat16++;
            if (i16.out_valid) begin
                if (sb16.size() == 0) chk("w16_unexpected_out", 1, 0);
                else begin
                    e16 = sb16[0];
                    chk("w16_quotient", i16.quotient, e16.q);
                    chk("w16_remainder", i16.remainder, e16.r);
                    chk("w16_div_by_zero", i16.div_by_zero, e16.z);
                    if (first16) begin
                        chk("w16_latency", lat16, e16.lat);
                        if (!e16.z) begin
                            chk("w16_q_times_d_plus_r", longint'(i16.quotient) * longint'(e16.b)
                                + longint'(i16.remainder), e16.a);
                            chk("w16_r_lt_d", longint'(i16.remainder < e16.b), 1);
                        end
                        first16 = 1'b0;
                        busy16  = 1'b0;
                    end
                    if (i16.out_ready) begin
                        void'(sb16.pop_front());
                        first16 = 1'b1;
                    end
                end
            end
            if (i16.in_valid && i16.in_ready) begin
                busy16 = 1'b1;
                lat16  = 0;
            end
        end
    end

    task automatic issue(input bit w16, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r, input logic z,
                         input bit push);
        exp_t e;
        int   n;
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
        e.lat = z ? 1 : (w16 ? 18 : 10);
        if (push) begin
            if (w16) sb16.push_back(e);
            else     sb8.push_back(e);
        end
        if (w16) begin
            i16.dividend = a; i16.divisor = b; i16.in_valid = 1'b1;
        end else begin
            i8.dividend = a[7:0]; i8.divisor = b[7:0]; i8.in_valid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if ((w16 ? i16.in_ready : i8.in_ready) == 1'b1) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        i8.in_valid  = 1'b0;
        i16.in_valid = 1'b0;
    endtask

    task automatic issue_model(input bit w16, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] all1;
        all1 = w16 ? 16'hFFFF : 16'h00FF;
        if (b == 16'd0) issue(w16, a, b, all1, a, 1'b1, 1'b1);
        else            issue(w16, a, b, a / b, a % b, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", longint'(sb8.size() + sb16.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          n;

        rst = 1'b1;
        i8.in_valid = 1'b0;  i8.out_ready = 1'b1;  i8.dividend = '0;  i8.divisor = '0;
        i16.in_valid = 1'b0; i16.out_ready = 1'b1; i16.dividend = '0; i16.divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_in_ready", i8.in_ready, 1);
        chk("rst_out_valid", i8.out_valid, 0);
        chk("rst_quotient", i8.quotient, 0);
        chk("rst_remainder", i8.remainder, 0);
        chk("rst_div_by_zero", i8.div_by_zero, 0);
        chk("rst_w16_in_ready", i16.in_ready, 1);

        issue(0, 100, 7,   14,  2,  1'b0, 1'b1);
        issue(0, 255, 1,   255, 0,  1'b0, 1'b1);
        issue(0, 5,   9,   0,   5,  1'b0, 1'b1);
        issue(0, 200, 200, 1,   0,  1'b0, 1'b1);
        issue(0, 37,  0,   255, 37, 1'b1, 1'b1);
        issue(0, 9,   3,   3,   0,  1'b0, 1'b1);
        drain();

        // Backpressure: result must hold while out_ready is low; busy-time requests are dropped.
        i8.out_ready = 1'b0;
        issue(0, 100, 7, 14, 2, 1'b0, 1'b1);
        n = 0;
        while (!i8.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_seen", i8.out_valid, 1);
        repeat (3) begin
            i8.dividend = 8'd77; i8.divisor = 8'd5; i8.in_valid = 1'b1;
            chk("bp_in_ready_low", i8.in_ready, 0);
            @(posedge clk); #1;
            i8.in_valid = 1'b0;
        end
        chk("bp_out_valid_held", i8.out_valid, 1);
        i8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_handshake", i8.in_ready, 1);
        chk("out_valid_after_handshake", i8.out_valid, 0);
        issue(0, 120, 11, 10, 10, 1'b0, 1'b1);
        drain();

        // Reset during RUN aborts the op and drops its result.
        issue(0, 200, 3, 66, 2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", i8.out_valid, 0);
        chk("midrst_in_ready", i8.in_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        issue(0, 50, 6, 8, 2, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, 255));
            b = (i % 6 == 5) ? 16'd0 : 16'($urandom_range(1, 255));
            issue_model(0, a, b);
        end

        issue(1, 1000,  7,     142,   6,    1'b0, 1'b1);
        issue(1, 65535, 255,   257,   0,    1'b0, 1'b1);
        issue(1, 3,     65535, 0,     3,    1'b0, 1'b1);
        issue(1, 1234,  0,     65535, 1234, 1'b1, 1'b1);
        issue(1, 40000, 40000, 1,     0,    1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i % 5 == 4) ? 16'd0 : 16'($urandom_range(1, 65535));
            issue_model(1, a, b);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
